c1_bus_master: RTL
==================

# c1_bus_master

Synthesizable, parametrised CPU-side requester for the C1 cache bus. It accepts byte-addressed 8/16/32-bit read and write requests on a valid/ready port and runs the split-phase C1 protocol: command with tag/set, offset, turnaround, then response beats. It returns read data with an error flag and keeps request, wait-cycle and timeout statistics. It replaces the behavioural CPU driver wherever a clocked master is needed in front of the cache.

## Interface
- TAG_W, 10, tag bits
- SET_W, 5, set-index bits
- OFFSET_W, 4, line-offset bits
- D1_W, 16, C1 data width; legal values 8, 16, 32
- CTR_W, 3, C1 command width
- TIMEOUT, 64, maximum WAIT cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master idle; request accepted on clk edge when req_valid && req_ready
- req_op  in  3  1=READ8, 2=READ16, 3=READ32, 5=WRITE8, 6=WRITE16, 7=WRITE32; any other value is illegal
- req_addr  in  TAG_W+SET_W+OFFSET_W  byte address {tag,set,offset}
- req_wdata  in  32  write data, little-endian, low bits used
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data, zero-extended; 0 for writes and errors
- rsp_err  out  1  qualifies rsp_valid: timeout, misalignment or illegal op
- a1_out  out  TAG_W+SET_W  address bus; offset is zero-extended
- c1_out / c1_oe / c1_in  out/out/in  CTR_W/1/CTR_W  command bus (tri-state split)
- d1_out / d1_oe / d1_in  out/out/in  D1_W/1/D1_W  data bus (tri-state split)
- stat_req, stat_wait, stat_timeout  out  32 each  saturating counters

## Operation
- Command codes: NONE=0, RESPONSE shares code 7 with WRITE32.
- Size S = 8, 16 or 32 bits. Beat count B = max(1, S/D1_W).
- States and transitions:
  - IDLE: req_ready=1.
  - Accept a legal, aligned request → CMD.
  - Accept a misaligned request (offset not a multiple of S/8) or an illegal op → ERR. ERR emits no bus activity.
  - CMD (1 cycle): c1_oe=1, c1_out=op, a1_out={tag,set}, d1_out=write beat 0 (writes), d1_oe=1.
  - ADDR (max(1, B−1) cycles): a1_out=offset, c1 held at op, d1_out=write beats 1..B−1. For reads, d1_oe stays 0 throughout. Exit → WAIT.
  - WAIT: c1_oe=d1_oe=0. When c1_in==7:
    - for a read, capture beat 0 from d1_in → RDATA if B>1, else → REL;
    - for a write → REL.
  - WAIT timeout: after TIMEOUT cycles with no response → REL with err.
  - RDATA (B−1 cycles): capture beats 1..B−1 on consecutive cycles, LSB beat first → REL.
  - REL (1 cycle): c1_oe=1, c1_out=NONE, rsp_valid=1 → IDLE.
  - ERR (1 cycle): rsp_valid=1, rsp_err=1, no bus drive → IDLE.
- Statistics:
  - stat_req increments on every accept.
  - stat_wait increments on every WAIT cycle.
  - stat_timeout increments on every timeout.
  - All counters saturate at 0xFFFFFFFF.
- Reset (asynchronous, any state):
  - state=IDLE; all oe=0; c1_out, d1_out, a1_out = 0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0; counters=0.
  - req_ready=1 once rst_n=1.
  - An in-flight transaction is dropped with no response.

## Timing
- Accept at edge E0. CMD occupies E0–E1, ADDR E1–E2, WAIT from E2.
- A response sampled at edge Er gives rsp_valid in cycle Er..Er+1 (B=1). Each extra read beat adds 1 cycle.
- Minimum READ8 latency: 4 cycles from accept edge to req_ready=1.
- Back-to-back: a new request is accepted only in IDLE. There is at most one outstanding transaction.
- c1_in values other than 7 during WAIT are ignored.
- A response in the same cycle the timeout counter reaches TIMEOUT wins: no error is flagged.
- Bus turnaround: master oe falls at the CMD/ADDR→WAIT edge and rises again only in REL.

## Test plan
- Reset mid-WAIT (rst_n low for 1 cycle) → all oe=0 immediately; no rsp_valid; stat_req=0; req_ready=1 after release.
- D1_W=16, READ8 addr 0x00123, slave answers 7 with d1_in=0x00AB on the first WAIT cycle → a1_out=0x0012 then 0x3; rsp_valid with rdata=0x000000AB, err=0; stat_wait=1.
- D1_W=16, READ32, beats 0x5678 then 0x1234 → rsp_rdata=0x12345678, B=2, rsp_valid one cycle after the second beat.
- D1_W=8, WRITE32 data 0xDEADBEEF → d1_out beats 0xEF, 0xBE, 0xAD, 0xDE over CMD+3 ADDR cycles; c1_out=7 throughout; rsp err=0 on slave 7.
- READ16 at offset 0x3 → ERR: rsp_err=1 the cycle after accept; c1_oe never asserted; stat_req=1.
- TIMEOUT=4, slave silent → exactly 4 WAIT cycles, then REL with rsp_err=1 and rsp_rdata=0; stat_timeout=1, stat_wait=4.

Source files
------------

// File: rtl/c1_bus_master.sv
// C1 cache-bus requester: takes CPU read/write requests and runs the split-phase
// C1 handshake (command, offset, turnaround, response beats), returning read data
// with an error flag and keeping saturating request/wait/timeout statistics.
module c1_bus_master #(
  parameter int unsigned TAG_W    = 10,
  parameter int unsigned SET_W    = 5,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned D1_W     = 16,
  parameter int unsigned CTR_W    = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   req_op,
  input  logic [TAG_W+SET_W+OFFSET_W-1:0] req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic [TAG_W+SET_W-1:0]       a1_out,
  output logic [CTR_W-1:0]             c1_out,
  output logic                         c1_oe,
  input  logic [CTR_W-1:0]             c1_in,
  output logic [D1_W-1:0]              d1_out,
  output logic                         d1_oe,
  input  logic [D1_W-1:0]              d1_in,
  output logic [31:0]                  stat_req,
  output logic [31:0]                  stat_wait,
  output logic [31:0]                  stat_timeout
);

  localparam int unsigned AW       = TAG_W + SET_W + OFFSET_W;
  localparam int unsigned A1_W     = TAG_W + SET_W;
  localparam int unsigned D1_BYTES = D1_W / 8;
  localparam logic [CTR_W-1:0] CmdNone     = '0;
  localparam logic [CTR_W-1:0] CmdResponse = CTR_W'(7);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWait, StRdata, StRel, StErr} state_e;

  // Transfer size in bytes from op[1:0]: 1, 2 or 4.
  function automatic logic [2:0] size_bytes(input logic [2:0] op);
    case (op[1:0])
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Number of D1 beats needed for one transfer, at least one.
  function automatic logic [2:0] beat_count(input logic [2:0] op);
    int unsigned n;
    n = 32'(size_bytes(op));
    if (n > D1_BYTES) return 3'(n / D1_BYTES);
    return 3'd1;
  endfunction

  // Keeps only the bytes belonging to the transfer size.
  function automatic logic [31:0] size_mask(input logic [2:0] op);
    case (op[1:0])
      2'd1:    return 32'h0000_00FF;
      2'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [2:0]    beat_q, beat_d;
  logic [31:0]   wait_q, wait_d;
  logic [31:0]   stat_req_q, stat_wait_q, stat_timeout_q;
  logic          req_inc, wait_inc, to_inc;

  logic [2:0]      nbeats;
  logic            req_legal, req_aligned;
  logic [D1_W-1:0] wbeat;

  assign nbeats      = beat_count(op_q);
  assign req_legal   = (req_op[1:0] != 2'd0);
  assign req_aligned = (req_addr[OFFSET_W-1:0] &
                        OFFSET_W'(size_bytes(req_op) - 3'd1)) == '0;
  assign wbeat       = D1_W'(wdata_q >> (32'(beat_q) * D1_W));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      op_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      beat_q         <= '0;
      wait_q         <= '0;
      stat_req_q     <= '0;
      stat_wait_q    <= '0;
      stat_timeout_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      if (req_inc)  stat_req_q     <= sat_inc(stat_req_q);
      if (wait_inc) stat_wait_q    <= sat_inc(stat_wait_q);
      if (to_inc)   stat_timeout_q <= sat_inc(stat_timeout_q);
    end
  end

  // Next-state and datapath updates for the protocol sequence.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    req_inc  = 1'b0;
    wait_inc = 1'b0;
    to_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          beat_d  = '0;
          wait_d  = '0;
          req_inc = 1'b1;
          state_d = (req_legal && req_aligned) ? StCmd : StErr;
        end
      end
      StCmd: begin
        beat_d  = 3'd1;
        state_d = StAddr;
      end
      StAddr: begin
        // Always at least one ADDR cycle, even when there is no second write beat.
        if (beat_q >= nbeats - 3'd1) state_d = StWait;
        else                         beat_d  = beat_q + 3'd1;
      end
      StWait: begin
        wait_inc = 1'b1;
        wait_d   = wait_q + 32'd1;
        // A response beats a timeout that would fire in the same cycle.
        if (c1_in == CmdResponse) begin
          if (op_q[2]) begin
            state_d = StRel;
          end else begin
            rdata_d = 32'(d1_in) & size_mask(op_q);
            beat_d  = 3'd1;
            state_d = (nbeats > 3'd1) ? StRdata : StRel;
          end
        end else if (TIMEOUT != 0 && wait_q == TIMEOUT - 1) begin
          err_d   = 1'b1;
          to_inc  = 1'b1;
          state_d = StRel;
        end
      end
      StRdata: begin
        rdata_d = rdata_q | (32'(d1_in) << (32'(beat_q) * D1_W));
        if (beat_q == nbeats - 3'd1) state_d = StRel;
        else                         beat_d  = beat_q + 3'd1;
      end
      StRel:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus drive and response outputs, decoded from the current state.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    a1_out    = '0;
    c1_out    = '0;
    c1_oe     = 1'b0;
    d1_out    = '0;
    d1_oe     = 1'b0;
    unique case (state_q)
      StCmd: begin
        c1_oe  = 1'b1;
        c1_out = CTR_W'(op_q);
        a1_out = addr_q[AW-1:OFFSET_W];
        d1_oe  = op_q[2];
        d1_out = op_q[2] ? wbeat : '0;
      end
      StAddr: begin
        c1_oe  = 1'b1;
        c1_out = CTR_W'(op_q);
        a1_out = A1_W'(addr_q[OFFSET_W-1:0]);
        d1_oe  = op_q[2] && (beat_q < nbeats);
        d1_out = d1_oe ? wbeat : '0;
      end
      StRel: begin
        c1_oe     = 1'b1;
        c1_out    = CmdNone;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || op_q[2]) ? 32'd0 : rdata_q;
      end
      StErr: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stat_req     = stat_req_q;
  assign stat_wait    = stat_wait_q;
  assign stat_timeout = stat_timeout_q;

endmodule
